// File: rtl/zigzag_rom_loader.sv
// zigzag_rom_loader: sequences the ioctl ROM download into the core write port, gating core reset on a validated load.
module zigzag_rom_loader #(
    parameter int EXPECT_BYTES = 20512,
    parameter int HOLD_CYCLES  = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        soft_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic [15:0] byte_count
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;
    state_t state_q, state_d;
    logic [15:0] dn_addr_q, dn_addr_d, byte_count_q, byte_count_d;
    logic [7:0] dn_data_q, dn_data_d;
    logic [HW-1:0] hold_q, hold_d;
    logic dn_wr_q, dn_wr_d, core_reset_q, core_reset_d, load_ok_q, load_ok_d;
    logic load_err_q, load_err_d, ovf_q, ovf_d, wr_d_q, dl_d_q;
    logic wr_rise, dl_rise, dl_fall;
    always_comb begin
        wr_rise      = ioctl_wr & ~wr_d_q;
        dl_rise      = ioctl_download & ~dl_d_q;
        dl_fall      = ~ioctl_download & dl_d_q;
        state_d      = state_q;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_wr_d      = 1'b0;
        load_ok_d    = load_ok_q;
        load_err_d   = load_err_q;
        byte_count_d = byte_count_q;
        hold_d       = hold_q;
        ovf_d        = ovf_q;
        if (dl_rise) begin
            state_d      = LOAD;
            byte_count_d = '0;
            ovf_d        = 1'b0;
            load_ok_d    = 1'b0;
            load_err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    // the dl_fall cycle still carries a valid strobe, so it is handled before the verdict
                    if (wr_rise && (ioctl_download || dl_d_q)) begin
                        if (ioctl_addr < 25'(EXPECT_BYTES)) begin
                            dn_addr_d    = ioctl_addr[15:0];
                            dn_data_d    = ioctl_dout;
                            dn_wr_d      = 1'b1;
                            byte_count_d = byte_count_q + (byte_count_q != 16'hFFFF ? 16'd1 : 16'd0);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (dl_fall) begin
                        if (byte_count_d == 16'(EXPECT_BYTES) && !ovf_d) begin
                            state_d = HOLD;
                            hold_d  = '0;
                        end else begin
                            state_d    = ERR;
                            load_err_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (soft_reset) begin
                        hold_d = '0;
                    end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        state_d   = RUN;
                        load_ok_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                RUN: begin
                    if (soft_reset) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
                default: ;
            endcase
        end
        core_reset_d = state_d != RUN;
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_q      <= 1'b0;
            core_reset_q <= 1'b1;
            load_ok_q    <= 1'b0;
            load_err_q   <= 1'b0;
            byte_count_q <= '0;
            hold_q       <= '0;
            ovf_q        <= 1'b0;
            wr_d_q       <= 1'b0;
            dl_d_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_wr_q      <= dn_wr_d;
            core_reset_q <= core_reset_d;
            load_ok_q    <= load_ok_d;
            load_err_q   <= load_err_d;
            byte_count_q <= byte_count_d;
            hold_q       <= hold_d;
            ovf_q        <= ovf_d;
            wr_d_q       <= ioctl_wr;
            dl_d_q       <= ioctl_download;
        end
    end
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign core_reset = core_reset_q;
    assign load_ok    = load_ok_q;
    assign load_err   = load_err_q;
    assign byte_count = byte_count_q;
endmodule

// File: tb/tb_zigzag_rom_loader.sv
// tb_zigzag_rom_loader: drives a full-size and a small-parameter loader from one ioctl stream against a rule-level model.
module tb_zigzag_rom_loader;
    localparam int EB0 = 20512, HC0 = 1024, EB1 = 40, HC1 = 6;
    logic clk_sys = 1'b0, reset_n = 1'b0, soft_reset = 1'b0, ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0] ioctl_dout = '0;
    logic [15:0] dn_addr [2];
    logic [7:0] dn_data [2];
    logic dn_wr [2], core_reset [2], load_ok [2], load_err [2];
    logic [15:0] byte_count [2];
    int eb [2] = '{EB0, EB1};
    int hc [2] = '{HC0, HC1};
    int m_cnt [2], m_pulses [2], seen [2];
    bit m_load [2], m_ovf [2], m_ok [2], m_err [2], m_run [2];
    int n_tests = 0, n_fail = 0;

    zigzag_rom_loader u_big (
        .clk_sys(clk_sys), .reset_n(reset_n), .soft_reset(soft_reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dn_addr(dn_addr[0]), .dn_data(dn_data[0]), .dn_wr(dn_wr[0]), .core_reset(core_reset[0]),
        .load_ok(load_ok[0]), .load_err(load_err[0]), .byte_count(byte_count[0])
    );
    zigzag_rom_loader #(.EXPECT_BYTES(EB1), .HOLD_CYCLES(HC1)) u_small (
        .clk_sys(clk_sys), .reset_n(reset_n), .soft_reset(soft_reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dn_addr(dn_addr[1]), .dn_data(dn_data[1]), .dn_wr(dn_wr[1]), .core_reset(core_reset[1]),
        .load_ok(load_ok[1]), .load_err(load_err[1]), .byte_count(byte_count[1])
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        for (int i = 0; i < 2; i++) if (dn_wr[i] === 1'b1) seen[i]++;
    end

    task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", tag, i, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_cr"}, i, 32'(core_reset[i]), 1);
            check({tag, "_wr"}, i, 32'(dn_wr[i]), 0);
            check({tag, "_addr"}, i, 32'(dn_addr[i]), 0);
            check({tag, "_data"}, i, 32'(dn_data[i]), 0);
            check({tag, "_ok"}, i, 32'(load_ok[i]), 0);
            check({tag, "_err"}, i, 32'(load_err[i]), 0);
            check({tag, "_cnt"}, i, 32'(byte_count[i]), 0);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_ok[i] = 0; m_err[i] = 0; m_run[i] = 0; m_load[i] = 0;
        end
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
        model_clear();
        for (int i = 0; i < 2; i++) begin
            m_load[i] = 1;
            check("start_cr", i, 32'(core_reset[i]), 1);
            check("start_ok", i, 32'(load_ok[i]), 0);
            check("start_err", i, 32'(load_err[i]), 0);
            check("start_cnt", i, 32'(byte_count[i]), 0);
        end
    endtask

    task automatic wr(input logic [24:0] a, input logic [7:0] d, input int hold);
        bit acc;
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            acc = m_load[i] && (int'(a) < eb[i]);
            if (m_load[i] && !acc) m_ovf[i] = 1;
            if (acc) begin
                if (m_cnt[i] < 65535) m_cnt[i]++;
                m_pulses[i]++;
            end
            check("dn_wr", i, 32'(dn_wr[i]), 32'(acc));
            if (acc) begin
                check("dn_addr", i, 32'(dn_addr[i]), 32'(a[15:0]));
                check("dn_data", i, 32'(dn_data[i]), 32'(d));
            end
            check("bcnt", i, 32'(byte_count[i]), 32'(m_cnt[i]));
        end
        for (int k = 1; k < hold; k++) tick();
        ioctl_wr = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) check("dn_wr_off", i, 32'(dn_wr[i]), 0);
    endtask

    task automatic end_dl();
        int first [2];
        bit good [2];
        ioctl_download = 1'b0;
        for (int i = 0; i < 2; i++) begin
            good[i] = m_load[i] && m_cnt[i] == eb[i] && !m_ovf[i];
            first[i] = -1;
        end
        for (int k = 1; k <= HC0 + 4; k++) begin
            tick();
            for (int i = 0; i < 2; i++) if (first[i] < 0 && core_reset[i] === 1'b0) first[i] = k;
        end
        for (int i = 0; i < 2; i++) begin
            check("run_lat", i, 32'(first[i]), good[i] ? 32'(hc[i] + 1) : 32'hFFFF_FFFF);
            check("load_ok", i, 32'(load_ok[i]), 32'(good[i]));
            check("load_err", i, 32'(load_err[i]), 32'(m_load[i] && !good[i]));
            check("end_cnt", i, 32'(byte_count[i]), 32'(m_cnt[i]));
            check("pulses", i, 32'(seen[i]), 32'(m_pulses[i]));
            m_ok[i] = good[i]; m_err[i] = m_load[i] && !good[i]; m_run[i] = good[i]; m_load[i] = 0;
        end
    endtask

    task automatic soft_pulse(input int n);
        int first [2];
        soft_reset = 1'b1;
        first = '{-1, -1};
        for (int k = 1; k <= n + HC0 + 3; k++) begin
            tick();
            if (k == n) soft_reset = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (k == 1) check("soft_cr", i, 32'(core_reset[i]), 1);
                else if (first[i] < 0 && core_reset[i] === 1'b0) first[i] = k;
            end
        end
        for (int i = 0; i < 2; i++) begin
            check("soft_lat", i, 32'(first[i]), m_run[i] ? 32'(n + hc[i]) : 32'hFFFF_FFFF);
            check("soft_ok", i, 32'(load_ok[i]), 32'(m_ok[i]));
            check("soft_err", i, 32'(load_err[i]), 32'(m_err[i]));
        end
    endtask

    task automatic shuffled_load(input int n, input bit extra);
        int q [$];
        int j, t;
        for (int a = 0; a < n; a++) q.push_back(a);
        for (int a = n - 1; a > 0; a--) begin
            j = $urandom_range(0, a);
            t = q[a]; q[a] = q[j]; q[j] = t;
        end
        start_dl();
        foreach (q[a]) wr(25'(q[a]), 8'($urandom_range(0, 255)), 1);
        if (extra) begin
            wr(25'(EB1), 8'h3C, 1);
            wr(25'h5020, 8'hC3, 1);
        end
        end_dl();
    endtask

    initial begin
        seen = '{0, 0};
        m_pulses = '{0, 0};
        model_clear();
        repeat (3) tick();
        check_reset_vals("rst");
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            soft_reset = 1'($urandom_range(0, 1));
            wr(25'($urandom_range(0, 100)), 8'($urandom_range(0, 255)), 1);
        end
        soft_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("idle_cr", i, 32'(core_reset[i]), 1);
            check("idle_ok", i, 32'(load_ok[i]), 0);
            check("idle_pulses", i, 32'(seen[i]), 0);
        end

        start_dl();
        for (int a = 0; a < EB0; a++) wr(25'(a), 8'($urandom_range(0, 255)), a == 16 ? 4 : 1);
        end_dl();
        soft_pulse(1);

        shuffled_load(EB1, 1'b1);
        shuffled_load(EB1, 1'b0);
        soft_pulse(3);

        start_dl();
        for (int k = 0; k < 100; k++) wr(25'($urandom_range(0, EB1 - 1)), 8'($urandom_range(0, 255)), 1);
        end_dl();
        soft_pulse(1);
        soft_pulse(2);

        start_dl();
        for (int k = 0; k < 5; k++) wr(25'(k + 7), 8'($urandom_range(0, 255)), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        ioctl_download = 1'b0;
        #1;
        reset_n = 1'b1;
        model_clear();
        repeat (4) tick();
        for (int k = 0; k < 4; k++) wr(25'(k), 8'($urandom_range(0, 255)), 1);
        for (int i = 0; i < 2; i++) begin
            check("post_cr", i, 32'(core_reset[i]), 1);
            check("post_cnt", i, 32'(byte_count[i]), 0);
            check("post_pulses", i, 32'(seen[i]), 32'(m_pulses[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
